// File: rtl/eeg_sample_loader_pkg.sv
// Shared types and constants for the EEG sample loader: ADC/intermediate-result
// widths, loader FSM states and the ADC-to-fixed-point conversion helper.
package eeg_sample_loader_pkg;

    localparam int NUM_PATCHES          = 60;
    localparam int PATCH_LEN            = 64;
    localparam int EEG_NUM_SAMPLES      = NUM_PATCHES * PATCH_LEN;
    localparam int EEG_ADC_LSHIFT       = 13;
    localparam int Q_STO_INT_RES_DOUBLE = 20;
    localparam int EEG_INPUT_MEM_BASE   = 0;

    localparam int ADC_W            = 16;
    localparam int INT_RES_DOUBLE_W = 30;
    localparam int INT_RES_ADDR_W   = 16;

    typedef logic [ADC_W-1:0]            AdcData_t;
    typedef logic [INT_RES_DOUBLE_W-1:0] IntResDouble_t;
    typedef logic [INT_RES_ADDR_W-1:0]   IntResAddr_t;

    typedef enum logic {SINGLE_WIDTH = 1'b0, DOUBLE_WIDTH = 1'b1} DataWidth_t;

    typedef enum logic [1:0] {
        EEG_LOADER_IDLE,
        EEG_LOADER_LOAD,
        EEG_LOADER_DRAIN
    } EegLoaderState_t;

    // Q10.20 result equal to adc/128; the zero sign bit keeps it non-negative.
    function automatic IntResDouble_t adcToFixed(input AdcData_t adc);
        return {1'b0, adc, {EEG_ADC_LSHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/eeg_sample_loader_sample_fifo.sv
// Two-entry synchronous FIFO of converted samples; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module eeg_sample_loader_sample_fifo
    import eeg_sample_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [29:0] data_i,
    output logic [29:0] data_o,
    output logic        full_o,
    output logic        empty_o
);

    IntResDouble_t entry_q [2];
    logic          rdPtr_q, rdPtr_d;
    logic          wrPtr_q, wrPtr_d;
    logic [1:0]    count_q, count_d;
    logic          doPush, doPop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign data_o  = entry_q[rdPtr_q];
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (doPop)  rdPtr_d = ~rdPtr_q;
        if (doPush) wrPtr_d = ~wrPtr_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            rdPtr_q    <= 1'b0;
            wrPtr_q    <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (doPush) entry_q[wrPtr_q] <= data_i;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/eeg_sample_loader.sv
// Loads raw ADC samples during EEG_LOAD, converts them to double-width fixed
// point and streams them to the intermediate-result memory through a 2-deep buffer.
module eeg_sample_loader
    import eeg_sample_loader_pkg::*;
#(
    parameter int NUM_SAMPLES = EEG_NUM_SAMPLES,
    parameter int BASE_ADDR   = EEG_INPUT_MEM_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sample_valid,
    input  logic [15:0] adc_data,
    output logic        wr_en,
    input  logic        wr_gnt,
    output logic [15:0] wr_addr,
    output logic [29:0] wr_data,
    output logic        wr_width,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int              CNT_W    = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(NUM_SAMPLES - 1);

    EegLoaderState_t  state_q, state_d;
    logic [CNT_W-1:0] acceptCnt_q, acceptCnt_d;
    logic [CNT_W-1:0] writeCnt_q, writeCnt_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, fifoFull, fifoEmpty;

    eeg_sample_loader_sample_fifo u_sample_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (adcToFixed(adc_data)),
        .data_o  (wr_data),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign wr_en    = !fifoEmpty;
    assign pop      = wr_en && wr_gnt;
    assign wr_addr  = IntResAddr_t'(BASE_ADDR) + IntResAddr_t'(writeCnt_q);
    assign wr_width = DOUBLE_WIDTH;
    assign overflow = overflow_q;
    assign busy     = (state_q != EEG_LOADER_IDLE) && !done;

    always_comb begin
        state_d     = state_q;
        acceptCnt_d = acceptCnt_q;
        writeCnt_d  = writeCnt_q;
        overflow_d  = overflow_q;
        push        = 1'b0;
        done        = 1'b0;
        if (pop) writeCnt_d = writeCnt_q + 1'b1;
        case (state_q)
            EEG_LOADER_IDLE: begin
                if (start) begin
                    acceptCnt_d = '0;
                    writeCnt_d  = '0;
                    overflow_d  = 1'b0;
                    state_d     = EEG_LOADER_LOAD;
                end
            end
            EEG_LOADER_LOAD: begin
                // A full buffer still takes the sample if the head leaves this cycle.
                if (sample_valid) begin
                    if (fifoFull && !pop) begin
                        overflow_d = 1'b1;
                    end else begin
                        push        = 1'b1;
                        acceptCnt_d = acceptCnt_q + 1'b1;
                        if (acceptCnt_q == CNT_PEN) state_d = EEG_LOADER_DRAIN;
                    end
                end
            end
            EEG_LOADER_DRAIN: begin
                if (fifoEmpty && (writeCnt_q == CNT_LAST)) begin
                    done    = 1'b1;
                    state_d = EEG_LOADER_IDLE;
                end
            end
            default: state_d = EEG_LOADER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EEG_LOADER_IDLE;
            acceptCnt_q <= '0;
            writeCnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acceptCnt_q <= acceptCnt_d;
            writeCnt_q  <= writeCnt_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_eeg_sample_loader.sv
// Scoreboard bench for eeg_sample_loader: a window-level reference model predicts
// every memory write, the busy/done/overflow flags and the buffer occupancy.
module tb_eeg_sample_loader;
    import eeg_sample_loader_pkg::*;

    localparam int N = EEG_NUM_SAMPLES;

    logic        clk = 1'b0;
    logic        rst_n, start, sample_valid, wr_gnt;
    logic [15:0] adc_data;
    logic        wr_en, wr_width, busy, done, overflow;
    logic [15:0] wr_addr;
    logic [29:0] wr_data;

    typedef struct {
        logic [15:0] addr;
        logic [29:0] data;
    } ExpWrite_t;

    ExpWrite_t expQ[$];
    int  checks = 0;
    int  failures = 0;
    bit  monitorOn = 1'b0;
    bit  mActive = 1'b0;
    bit  mOpen = 1'b0;
    bit  mOverflow = 1'b0;
    int  mOcc = 0;
    int  mAccepted = 0;
    int  mWritten = 0;

    always #5 clk = ~clk;

    eeg_sample_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sample_valid (sample_valid),
        .adc_data     (adc_data),
        .wr_en        (wr_en),
        .wr_gnt       (wr_gnt),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_width     (wr_width),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and model: compare outputs against the model, then advance the
    // model with the inputs the DUT will sample on the coming rising edge.
    always @(negedge clk) begin
        if (monitorOn) begin
            bit expDone;
            bit popNow;
            bit wasFull;
            ExpWrite_t e;
            expDone = mActive && !mOpen && (mOcc == 0) && (mWritten == N);
            checkOutput("wr_en", {31'b0, wr_en}, {31'b0, mOcc > 0});
            checkOutput("busy", {31'b0, busy}, {31'b0, mActive && !expDone});
            checkOutput("done", {31'b0, done}, {31'b0, expDone});
            checkOutput("overflow", {31'b0, overflow}, {31'b0, mOverflow});
            checkOutput("wr_width", {31'b0, wr_width}, 32'd1);
            if (wr_en && wr_gnt) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_write", {16'b0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wr_addr", {16'b0, wr_addr}, {16'b0, e.addr});
                    checkOutput("wr_data", {2'b0, wr_data}, {2'b0, e.data});
                end
            end
            if (!rst_n) begin
                mActive = 0; mOpen = 0; mOverflow = 0; mOcc = 0;
                expQ.delete();
            end else begin
                wasFull = (mOcc == 2);
                popNow  = (mOcc > 0) && wr_gnt;
                if (popNow) begin
                    mOcc--;
                    mWritten++;
                end
                if (expDone) begin
                    mActive = 0;
                end else if (!mActive && start) begin
                    mActive = 1; mOpen = 1; mOverflow = 0;
                    mAccepted = 0; mWritten = 0;
                end else if (mOpen && sample_valid) begin
                    if (wasFull && !popNow) begin
                        mOverflow = 1;
                    end else begin
                        expQ.push_back('{addr: 16'(mAccepted), data: 30'(adc_data) * 30'd8192});
                        mAccepted++;
                        mOcc++;
                        if (mAccepted == N) mOpen = 0;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input bit valid, input logic [15:0] data, input bit gnt, input bit st);
        sample_valid = valid;
        adc_data     = data;
        wr_gnt       = gnt;
        start        = st;
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while (mActive && n < limit) begin
            applyStimulus(0, 16'h0, 1, 0);
            n++;
        end
        checkOutput("idle_timeout", {31'b0, mActive}, 32'd0);
    endtask

    function automatic logic [15:0] randSample();
        int sel = $urandom_range(0, 9);
        if (sel == 0) return 16'hFFFF;
        if (sel == 1) return 16'h0000;
        return 16'($urandom);
    endfunction

    initial begin
        int guard;
        rst_n = 0; start = 0; sample_valid = 0; adc_data = 0; wr_gnt = 1;
        @(posedge clk);
        #1;
        monitorOn = 1;
        applyStimulus(1, 16'h1111, 1, 1);
        checkOutput("rst_wr_en", {31'b0, wr_en}, 32'd0);
        checkOutput("rst_wr_addr", {16'b0, wr_addr}, 32'd0);
        checkOutput("rst_wr_data", {2'b0, wr_data}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1;

        for (int i = 0; i < 3; i++) applyStimulus(1, 16'($urandom), 1, 0);
        checkOutput("idle_strobe_wr_en", {31'b0, wr_en}, 32'd0);

        $display("[TB] window A: paced ramp, grant always high");
        applyStimulus(0, 16'h0, 1, 1);
        for (int k = 0; k < N; k++) begin
            applyStimulus(1, 16'(k), 1, k == 500);
            for (int j = 0; j < 3; j++) applyStimulus(0, 16'h0, 1, 0);
        end
        waitIdle(100);
        checkOutput("A_overflow", {31'b0, overflow}, 32'd0);

        $display("[TB] window B: stall, overflow and random traffic");
        applyStimulus(0, 16'h0, 1, 1);
        applyStimulus(1, 16'hFFFF, 0, 0);
        applyStimulus(1, 16'h0000, 0, 0);
        applyStimulus(1, 16'h1234, 0, 0);
        checkOutput("stall_overflow", {31'b0, overflow}, 32'd1);
        checkOutput("stall_head", {2'b0, wr_data}, 32'h1FFF_E000);
        for (int i = 0; i < 10; i++) applyStimulus(1, randSample(), 1, 0);
        guard = 0;
        while (mOpen && guard < 40000) begin
            applyStimulus($urandom_range(0, 3) != 0, randSample(), $urandom_range(0, 3) != 0, 0);
            guard++;
        end
        waitIdle(100);

        $display("[TB] window C: reset mid-load then full-rate reload");
        applyStimulus(0, 16'h0, 1, 1);
        guard = 0;
        while (mAccepted < 100 && guard < 2000) begin
            applyStimulus($urandom_range(0, 1) != 0, randSample(), $urandom_range(0, 2) != 0, 0);
            guard++;
        end
        rst_n = 0;
        applyStimulus(1, randSample(), 1, 0);
        checkOutput("midrst_wr_en", {31'b0, wr_en}, 32'd0);
        checkOutput("midrst_wr_addr", {16'b0, wr_addr}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_overflow", {31'b0, overflow}, 32'd0);
        rst_n = 1;
        for (int i = 0; i < 4; i++) applyStimulus(1, randSample(), 1, 0);
        applyStimulus(0, 16'h0, 1, 1);
        guard = 0;
        while (mOpen && guard < 10000) begin
            applyStimulus(1, randSample(), 1, 0);
            guard++;
        end
        waitIdle(100);

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
